// File: rtl/iter_divider32.sv
// Multi-cycle radix-2 restoring divider serving MIPS div/divu.
// Quotient goes to LO and remainder to HI; done pulses once per completed op.
module iter_divider32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             bzero_q, bzero_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  assign shifted = {prem_q[WIDTH-1:0], sr_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, bmag_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    prem_d  = prem_q;
    sr_d    = sr_q;
    bmag_d  = bmag_q;
    araw_d  = araw_q;
    bzero_d = bzero_q;
    negq_d  = negq_q;
    negr_d  = negr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          araw_d  = inA;
          bzero_d = (inB == '0);
          bmag_d  = magnitude(inB, signed_op);
          sr_d    = magnitude(inA, signed_op);
          negq_d  = signed_op & (inA[WIDTH-1] ^ inB[WIDTH-1]);
          negr_d  = signed_op & inA[WIDTH-1];
          prem_d  = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Partial remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag.
        if (!diff[WIDTH]) begin
          prem_d = diff;
          sr_d   = {sr_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d = shifted;
          sr_d   = {sr_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (bzero_q) begin
          quot_d = '1;
          rem_d  = araw_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = apply_sign(sr_q, negq_q);
          rem_d  = apply_sign(prem_q[WIDTH-1:0], negr_q);
          dbz_d  = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Datapath working registers are only meaningful while an op is in flight.
  always_ff @(posedge clock) begin
    prem_q  <= prem_d;
    sr_q    <= sr_d;
    bmag_q  <= bmag_d;
    araw_q  <= araw_d;
    bzero_q <= bzero_d;
    negq_q  <= negq_d;
    negr_q  <= negr_d;
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
